// File: rtl/trigger_sequencer_pkg.sv
// Shared types and default sizing for the trigger/done sequencer.
package trigger_sequencer_pkg;

   // Default watchdog limit (cycles per WAIT) and count-field width.
   localparam int DEF_TIMEOUT_CYCLES = 32;
   localparam int DEF_CNT_W          = 8;

   // Sequencer control states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRE   = 2'd1,
      WAIT   = 2'd2,
      REPORT = 2'd3
   } state_t;

endpackage : trigger_sequencer_pkg

// File: rtl/trigger_sequencer_if.sv
// Job request / completion and trigger / done signals of the sequencer.
//
// Handshake semantics: a request transfers on a rising edge where both
// req_valid and req_ready are high; upstream must hold req_valid and
// req_count stable until that edge. The completion record (cmpl_valid with
// cmpl_error/cmpl_rounds) is a one-cycle strobe with no back-pressure.
// trigger and done are single-cycle pulses with no ready signal.
interface trigger_sequencer_if
   import trigger_sequencer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             req_valid;
   logic             req_ready;
   logic [CNT_W-1:0] req_count;
   logic             trigger;
   logic             done;
   logic             busy;
   logic             cmpl_valid;
   logic             cmpl_error;
   logic [CNT_W-1:0] cmpl_rounds;

   // Sequencer side.
   modport master (
      input  req_valid, req_count, done,
      output req_ready, trigger, busy, cmpl_valid, cmpl_error, cmpl_rounds
   );

   // Upstream requester plus downstream responder side.
   modport slave (
      output req_valid, req_count, done,
      input  req_ready, trigger, busy, cmpl_valid, cmpl_error, cmpl_rounds
   );
endinterface : trigger_sequencer_if

// File: rtl/trigger_sequencer_seq_watchdog.sv
// Per-round wait counter: counts WAIT cycles and flags the last allowed one.
module seq_watchdog #(
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Count enabled cycles from zero; clear restarts the round.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expired = enable && (count == LAST);
endmodule : seq_watchdog

// File: rtl/trigger_sequencer.sv
// Initiator of the trigger/done handshake: one trigger per round, waits for
// done under a watchdog, then reports rounds completed and a timeout flag.
module trigger_sequencer
   import trigger_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   trigger_sequencer_if.master  bus,
   output state_t               dbg_state
);
   state_t           state, next_state;
   logic [CNT_W-1:0] target_q;
   logic [CNT_W-1:0] rounds_q;
   logic [CNT_W-1:0] rounds_inc;
   logic             err_q;
   logic             trigger_q;
   logic             accept;
   logic             expired;

   assign bus.req_ready = (state == IDLE) && !rst;
   assign accept        = bus.req_ready && bus.req_valid;
   assign rounds_inc    = rounds_q + CNT_W'(1);

   seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == FIRE),
      .enable  (state == WAIT),
      .expired (expired)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; done takes priority over the watchdog.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = (bus.req_count == '0) ? REPORT : FIRE;
            end
         end
         FIRE: next_state = WAIT;
         WAIT: begin
            if (bus.done) begin
               next_state = (rounds_inc == target_q) ? REPORT : FIRE;
            end else if (expired) begin
               next_state = REPORT;
            end
         end
         REPORT:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Job target, round counter, error flag and the registered trigger pulse.
   // trigger_q is loaded from next_state so it is high in the FIRE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         target_q  <= '0;
         rounds_q  <= '0;
         err_q     <= 1'b0;
         trigger_q <= 1'b0;
      end else begin
         trigger_q <= (next_state == FIRE);
         if (accept) begin
            target_q <= bus.req_count;
            rounds_q <= '0;
            err_q    <= 1'b0;
         end else if (state == WAIT) begin
            if (bus.done) begin
               rounds_q <= rounds_inc;
            end else if (expired) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.trigger     = trigger_q;
   assign bus.busy        = (state != IDLE);
   assign bus.cmpl_valid  = (state == REPORT);
   assign bus.cmpl_error  = (state == REPORT) ? err_q : 1'b0;
   assign bus.cmpl_rounds = (state == REPORT) ? rounds_q : '0;
   assign dbg_state       = state;
endmodule : trigger_sequencer

// File: tb/tb_trigger_sequencer.sv
// Bench for trigger_sequencer: random jobs and responder delays, expected
// triggers and completion records queued by a job-level model and checked
// by an independent monitor.
module tb_trigger_sequencer;
   import trigger_sequencer_pkg::*;

   localparam int T  = 32;
   localparam int CW = 8;
   localparam int EW = 32 + 1 + CW;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t dbg_state;
   int     cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   trigger_sequencer_if #(.CNT_W(CW)) bus ();

   trigger_sequencer #(
      .TIMEOUT_CYCLES (T),
      .CNT_W          (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   logic resp_done  = 1'b0;
   logic stray_done = 1'b0;
   assign bus.done = resp_done | stray_done;

   // ---------------- scoreboard ----------------
   logic [31:0]   trig_q[$];
   logic [EW-1:0] exp_q[$];
   int unsigned   dly_q[$];
   int unsigned   plan[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            last_cmpl_cyc;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_cmpl(input int c, input bit err, input int rounds);
      exp_q.push_back({32'(c), err, CW'(rounds)});
      last_cmpl_cyc = c;
   endtask

   // Job-level model: trigger k follows the previous done by one cycle, a
   // done d cycles after a trigger counts when 1 <= d <= T (WAIT spans the
   // T cycles after the trigger), otherwise the round times out and the
   // record appears one cycle after the last WAIT cycle.
   task automatic model_job(input int c0, input int cnt, input int unsigned dl[$]);
      int t = c0 + 1;
      int rounds = 0;
      if (cnt == 0) begin
         push_cmpl(c0 + 1, 1'b0, 0);
         return;
      end
      for (int k = 0; k < cnt; k++) begin
         trig_q.push_back(32'(t));
         dly_q.push_back(dl[k]);
         if (dl[k] >= 1 && dl[k] <= T) begin
            rounds++;
            if (rounds == cnt) begin
               push_cmpl(t + int'(dl[k]) + 1, 1'b0, rounds);
               return;
            end
            t = t + int'(dl[k]) + 1;
         end else begin
            push_cmpl(t + T + 1, 1'b1, rounds);
            return;
         end
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      logic [EW-1:0] e;
      if (bus.trigger) begin
         if (trig_q.size() == 0) chk("unexpected_trigger", 1, 0);
         else chk("trigger_cycle", cyc, trig_q.pop_front());
      end
      if (bus.cmpl_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_cmpl", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("cmpl_cycle", cyc, e[EW-1 -: 32]);
            chk("cmpl_error", bus.cmpl_error, e[CW]);
            chk("cmpl_rounds", bus.cmpl_rounds, e[CW-1:0]);
            chk("cmpl_req_ready", bus.req_ready, 0);
         end
      end else begin
         chk("cmpl_fields_quiet", {bus.cmpl_error, bus.cmpl_rounds}, 0);
      end
   end

   // ---------------- responder: done d cycles after each trigger ----------------
   always begin : responder
      int unsigned d;
      @(negedge clk);
      if (bus.trigger) begin
         d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
         if (d != 0) begin
            repeat (d - 1) @(negedge clk);
            @(posedge clk); #1 resp_done = 1'b1;
            @(posedge clk); #1 resp_done = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic fill_plan(input int n, input int unsigned d);
      for (int i = 0; i < n; i++) plan.push_back(d);
   endtask

   function automatic int unsigned rand_delay();
      int unsigned r = $urandom_range(0, 9);
      if (r == 0) return 0;
      if (r == 1) return T;
      if (r == 2) return $urandom_range(T + 1, T + 2);
      return $urandom_range(1, T - 1);
   endfunction

   task automatic issue(input int cnt, output int c0);
      int guard = 0;
      @(negedge clk);
      while (!bus.req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("req_ready_before_issue", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_count = CW'(cnt);
      c0 = cyc;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_count = CW'($urandom);
   endtask

   task automatic run_job(input int cnt);
      int c0;
      int guard = 0;
      int budget = cnt * (T + 4) + 40;
      issue(cnt, c0);
      model_job(c0, cnt, plan);
      plan.delete();
      @(negedge clk);
      chk("busy_after_accept", bus.busy, 1);
      while ((trig_q.size() != 0 || exp_q.size() != 0) && guard < budget) begin
         @(negedge clk);
         guard++;
      end
      chk("job_finished_in_budget", trig_q.size() + exp_q.size(), 0);
      trig_q.delete();
      exp_q.delete();
      while (cyc < last_cmpl_cyc + 1) @(negedge clk);
      if (cyc == last_cmpl_cyc + 1) chk("req_ready_after_cmpl", bus.req_ready, 1);
      repeat (4) @(negedge clk);
      dly_q.delete();
      chk("idle_busy", bus.busy, 0);
      chk("idle_req_ready", bus.req_ready, 1);
   endtask

   task automatic reset_mid_job();
      int c0;
      issue(3, c0);
      trig_q.push_back(32'(c0 + 1));
      dly_q.push_back(11);
      while (cyc < c0 + 5) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_trigger", bus.trigger, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_cmpl_valid", bus.cmpl_valid, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_state", dbg_state, IDLE);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_mid_reset", bus.req_ready, 1);
      while (cyc < c0 + 16) @(negedge clk);
      chk("late_done_ignored_busy", bus.busy, 0);
      chk("late_done_no_trigger_left", trig_q.size(), 0);
   endtask

   task automatic stray_done_idle();
      @(posedge clk); #1 stray_done = 1'b1;
      @(posedge clk); #1 stray_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_done_busy", bus.busy, 0);
      chk("stray_done_state", dbg_state, IDLE);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.req_valid = 1'b0;
      bus.req_count = '0;
      repeat (2) @(negedge clk);
      chk("reset_req_ready", bus.req_ready, 0);
      chk("reset_trigger", bus.trigger, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_cmpl_valid", bus.cmpl_valid, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", bus.req_ready, 1);

      fill_plan(1, 11);  run_job(1);      // single round
      fill_plan(3, 11);  run_job(3);      // three rounds
      run_job(0);                         // empty job
      plan.push_back(11); plan.push_back(0);
      run_job(2);                         // timeout in round 2
      fill_plan(1, T);   run_job(1);      // done on the last WAIT cycle
      fill_plan(1, T + 1); run_job(1);    // done one cycle too late
      reset_mid_job();
      stray_done_idle();
      fill_plan(2, 5);   run_job(2);      // normal job after reset
      fill_plan(255, 1); run_job(255);    // maximum round count

      for (int j = 0; j < 25; j++) begin
         int cnt = int'($urandom_range(0, 6));
         for (int k = 0; k < cnt; k++) plan.push_back(rand_delay());
         run_job(cnt);
         if ($urandom_range(0, 3) == 0) stray_done_idle();
      end

      chk("trig_q_drained", trig_q.size(), 0);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "time limit");
   end
endmodule : tb_trigger_sequencer
